// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt vector controller:
// request FSM encoding, ID width helper and vector-table slicing.
package irq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

    localparam int MAX_SRC    = 16;
    localparam int MAX_ADDR_W = 64;
    localparam int TBL_W      = MAX_SRC * MAX_ADDR_W;

    typedef logic [TBL_W-1:0] vec_tbl_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry idx of a flattened table whose entries are addr_w bits wide.
    function automatic logic [MAX_ADDR_W-1:0] vec_slice(input vec_tbl_t    tbl,
                                                        input int unsigned addr_w,
                                                        input int unsigned idx);
        return MAX_ADDR_W'(tbl >> (idx * addr_w));
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the highest set bit.
module irq_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] vec_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec_i[i]) idx_o = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Nested interrupt controller: edge-latched pending sources, masking and
// priority above the current in-service level, req/ack handshake, eret pop.
module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter int                          NUM_SRC    = 4,
    parameter int                          ADDR_W     = 32,
    parameter logic [NUM_SRC*ADDR_W-1:0]   VEC_TABLE  = {32'h00AB, 32'h0078, 32'h0045, 32'h0000},
    parameter int                          NEST_DEPTH = 4,
    localparam int                         ID_W       = id_width(NUM_SRC),
    localparam int                         LVL_W      = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               glb_en,
    output logic               irq_req,
    output logic [ADDR_W-1:0]  irq_vec,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_eret,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service,
    output logic [LVL_W-1:0]   nest_lvl,
    output logic               err
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] edge_det, above, eligible;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  vec_q, vec_d;
    logic [ID_W-1:0]    stack_q [NEST_DEPTH];
    logic [LVL_W-1:0]   nest_q, nest_d, push_lvl;
    logic [ID_W-1:0]    top_id;
    logic               err_q, err_d;
    logic               can_nest, elig_vld, ack_ok, pop;
    logic [ID_W-1:0]    elig_idx;

    assign edge_det = irq_in & ~irq_q;
    assign ack_ok   = irq_ack && (state_q == ST_REQ);
    assign pop      = irq_eret && (nest_q != '0);
    assign err_d    = (irq_ack && (state_q != ST_REQ)) || (irq_eret && (nest_q == '0));
    assign can_nest = glb_en && (nest_q < LVL_W'(NEST_DEPTH));

    // Only sources strictly above the innermost in-service id may interrupt.
    always_comb begin
        top_id = '0;
        for (int l = 0; l < NEST_DEPTH; l++) begin
            if (LVL_W'(l + 1) == nest_q) top_id = stack_q[l];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            above[i] = (nest_q == '0) || (ID_W'(i) > top_id);
        end
    end

    assign eligible = pending_q & ~irq_mask & above & {NUM_SRC{can_nest}};

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .vec_i   (eligible),
        .valid_o (elig_vld),
        .idx_o   (elig_idx)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (elig_vld) begin
                    state_d = ST_REQ;
                    id_d    = elig_idx;
                    vec_d   = ADDR_W'(vec_slice(vec_tbl_t'(VEC_TABLE), ADDR_W, 32'(elig_idx)));
                end
            end
            ST_REQ: begin
                if (ack_ok) begin
                    state_d = ST_IDLE;
                end else if (!eligible[id_q] || (elig_vld && (elig_idx > id_q))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A simultaneous edge on the acked source re-arms it.
    assign pending_d = (pending_q & ~({NUM_SRC{ack_ok}} & (NUM_SRC'(1) << id_q))) | edge_det;

    // Same-cycle eret and ack: pop first, so the push lands on the freed slot.
    assign push_lvl = nest_q - LVL_W'(pop);
    assign nest_d   = push_lvl + LVL_W'(ack_ok);

    always_comb begin
        in_service = '0;
        for (int l = 0; l < NEST_DEPTH; l++) begin
            if (LVL_W'(l) < nest_q) in_service[stack_q[l]] = 1'b1;
        end
    end

    // irq_q follows the lines even in reset so held-high lines give no edge on release.
    always_ff @(posedge clk) begin
        irq_q <= irq_in;
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            nest_q    <= '0;
            id_q      <= '0;
            vec_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            nest_q    <= nest_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NEST_DEPTH; l++) begin
            if (!rst && ack_ok && (LVL_W'(l) == push_lvl)) stack_q[l] <= id_q;
        end
    end

    assign irq_req  = (state_q == ST_REQ);
    assign irq_vec  = vec_q;
    assign irq_id   = id_q;
    assign pending  = pending_q;
    assign nest_lvl = nest_q;
    assign err      = err_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed table-driven bench for irq_vector_ctrl, with a second instance
// at NEST_DEPTH=2 sharing the stimulus to exercise the full-stack case.
module tb_irq_vector_ctrl;

    typedef struct {
        logic [3:0]  in;
        logic [3:0]  mask;
        logic        glb;
        logic        ack;
        logic        eret;
        logic        req;
        logic [31:0] vec;
        logic [1:0]  id;
        logic [3:0]  pend;
        logic [3:0]  insvc;
        logic [2:0]  nest;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in, irq_mask;
    logic        glb_en, irq_ack, irq_eret;
    logic        irq_req, err;
    logic [31:0] irq_vec;
    logic [1:0]  irq_id;
    logic [3:0]  pending, in_service;
    logic [2:0]  nest_lvl;
    logic        req2, err2;
    logic [31:0] vec2;
    logic [1:0]  id2;
    logic [3:0]  pend2, insvc2;
    logic [1:0]  nest2;

    int tests  = 0;
    int failed = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    irq_vector_ctrl u_dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .glb_en(glb_en),
        .irq_req(irq_req), .irq_vec(irq_vec), .irq_id(irq_id), .irq_ack(irq_ack),
        .irq_eret(irq_eret), .pending(pending), .in_service(in_service),
        .nest_lvl(nest_lvl), .err(err)
    );

    irq_vector_ctrl #(.NEST_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .glb_en(glb_en),
        .irq_req(req2), .irq_vec(vec2), .irq_id(id2), .irq_ack(irq_ack),
        .irq_eret(irq_eret), .pending(pend2), .in_service(insvc2),
        .nest_lvl(nest2), .err(err2)
    );

    function automatic vec_t r(input logic [3:0] in, input logic [3:0] mask, input logic glb,
                               input logic ack, input logic eret, input logic req,
                               input logic [31:0] vec, input logic [1:0] id,
                               input logic [3:0] pend, input logic [3:0] insvc,
                               input logic [2:0] nest, input logic e);
        vec_t v;
        v.in = in; v.mask = mask; v.glb = glb; v.ack = ack; v.eret = eret;
        v.req = req; v.vec = vec; v.id = id; v.pend = pend; v.insvc = insvc;
        v.nest = nest; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] in, input logic ack, input logic eret);
        irq_in = in; irq_ack = ack; irq_eret = eret;
    endtask

    initial begin
        rst = 1'b1; irq_in = 4'hF; irq_mask = 4'h0; glb_en = 1'b1; irq_ack = 1'b0; irq_eret = 1'b0;

        //      in    mask glb ack eret req vec     id pend  insvc nest err
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0)); // 0
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h2, 4'h0, 0, 0)); // single
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 1, 32'h45, 1, 4'h2, 4'h0, 0, 0));
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 1, 32'h45, 1, 4'h2, 4'h0, 0, 0));
        tbl.push_back(r(4'h2, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h2, 1, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0)); // 5
        tbl.push_back(r(4'h9, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h9, 4'h0, 0, 0)); // priority
        tbl.push_back(r(4'h9, 4'h0, 1, 0, 0, 1, 32'hAB, 3, 4'h9, 4'h0, 0, 0));
        tbl.push_back(r(4'h9, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h1, 4'h8, 1, 0));
        tbl.push_back(r(4'h9, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h1, 4'h0, 0, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 0, 1, 32'h00, 0, 4'h1, 4'h0, 0, 0)); // 10
        tbl.push_back(r(4'h0, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h1, 1, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h2, 4'h0, 0, 0)); // nesting
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 1, 32'h45, 1, 4'h2, 4'h0, 0, 0));
        tbl.push_back(r(4'h2, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h2, 1, 0)); // 15
        tbl.push_back(r(4'h6, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h4, 4'h2, 1, 0));
        tbl.push_back(r(4'h6, 4'h0, 1, 0, 0, 1, 32'h78, 2, 4'h4, 4'h2, 1, 0));
        tbl.push_back(r(4'h6, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h6, 2, 0));
        tbl.push_back(r(4'h7, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h1, 4'h6, 2, 0));
        tbl.push_back(r(4'h7, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h1, 4'h6, 2, 0)); // 20
        tbl.push_back(r(4'h7, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h1, 4'h2, 1, 0));
        tbl.push_back(r(4'h7, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h1, 4'h2, 1, 0));
        tbl.push_back(r(4'h7, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h1, 4'h0, 0, 0));
        tbl.push_back(r(4'h7, 4'h0, 1, 0, 0, 1, 32'h00, 0, 4'h1, 4'h0, 0, 0));
        tbl.push_back(r(4'h7, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h1, 1, 0)); // 25
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(r(4'h4, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h4, 4'h0, 0, 0)); // mask/retract
        tbl.push_back(r(4'h4, 4'h0, 1, 0, 0, 1, 32'h78, 2, 4'h4, 4'h0, 0, 0));
        tbl.push_back(r(4'h4, 4'h4, 1, 0, 0, 0, 32'h00, 0, 4'h4, 4'h0, 0, 0));
        tbl.push_back(r(4'h4, 4'h4, 1, 0, 0, 0, 32'h00, 0, 4'h4, 4'h0, 0, 0)); // 30
        tbl.push_back(r(4'h4, 4'h0, 1, 0, 0, 1, 32'h78, 2, 4'h4, 4'h0, 0, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h4, 1, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 1)); // errors
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0)); // 35
        tbl.push_back(r(4'h0, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h0, 0, 1));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(r(4'h8, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h8, 4'h0, 0, 0)); // glb_en retract
        tbl.push_back(r(4'h8, 4'h0, 1, 0, 0, 1, 32'hAB, 3, 4'h8, 4'h0, 0, 0));
        tbl.push_back(r(4'h8, 4'h0, 0, 0, 0, 0, 32'h00, 0, 4'h8, 4'h0, 0, 0)); // 40
        tbl.push_back(r(4'h8, 4'h0, 1, 0, 0, 1, 32'hAB, 3, 4'h8, 4'h0, 0, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h8, 1, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0));
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h2, 4'h0, 0, 0)); // eret+ack
        tbl.push_back(r(4'h2, 4'h0, 1, 0, 0, 1, 32'h45, 1, 4'h2, 4'h0, 0, 0)); // 45
        tbl.push_back(r(4'h2, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h2, 1, 0));
        tbl.push_back(r(4'h6, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h4, 4'h2, 1, 0));
        tbl.push_back(r(4'h6, 4'h0, 1, 0, 0, 1, 32'h78, 2, 4'h4, 4'h2, 1, 0));
        tbl.push_back(r(4'h6, 4'h0, 1, 1, 1, 0, 32'h00, 0, 4'h0, 4'h4, 1, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0)); // 50
        tbl.push_back(r(4'h8, 4'h0, 1, 0, 0, 0, 32'h00, 0, 4'h8, 4'h0, 0, 0)); // edge+ack
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 0, 1, 32'hAB, 3, 4'h8, 4'h0, 0, 0));
        tbl.push_back(r(4'h8, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h8, 4'h8, 1, 0));
        tbl.push_back(r(4'h8, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h8, 4'h0, 0, 0));
        tbl.push_back(r(4'h8, 4'h0, 1, 0, 0, 1, 32'hAB, 3, 4'h8, 4'h0, 0, 0)); // 55
        tbl.push_back(r(4'h8, 4'h0, 1, 1, 0, 0, 32'h00, 0, 4'h0, 4'h8, 1, 0));
        tbl.push_back(r(4'h0, 4'h0, 1, 0, 1, 0, 32'h00, 0, 4'h0, 4'h0, 0, 0));

        // Reset with all lines high, then release with lines still high.
        repeat (2) step();
        chk("rst_req", -1, 32'(irq_req), 32'd0);
        chk("rst_pend", -1, 32'(pending), 32'd0);
        chk("rst_nest", -1, 32'(nest_lvl), 32'd0);
        chk("rst_err", -1, 32'(err), 32'd0);
        chk("rst_nest2", -1, 32'(nest2), 32'd0);
        rst = 1'b0;
        repeat (2) step();
        chk("rel_req", -2, 32'(irq_req), 32'd0);
        chk("rel_pend", -2, 32'(pending), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            irq_in = tbl[i].in; irq_mask = tbl[i].mask; glb_en = tbl[i].glb;
            irq_ack = tbl[i].ack; irq_eret = tbl[i].eret;
            step();
            chk("req", i, 32'(irq_req), 32'(tbl[i].req));
            chk("pend", i, 32'(pending), 32'(tbl[i].pend));
            chk("insvc", i, 32'(in_service), 32'(tbl[i].insvc));
            chk("nest", i, 32'(nest_lvl), 32'(tbl[i].nest));
            chk("err", i, 32'(err), 32'(tbl[i].err));
            if (tbl[i].req) begin
                chk("vec", i, irq_vec, tbl[i].vec);
                chk("id", i, 32'(irq_id), 32'(tbl[i].id));
            end
        end

        // Reset mid-REQ with ack asserted: no push survives.
        drive(4'h2, 0, 0); step(); step();
        chk("mreq_req", 100, 32'(irq_req), 32'd1);
        rst = 1'b1; irq_ack = 1'b1; step();
        rst = 1'b0; irq_ack = 1'b0;
        chk("mreq_req", 101, 32'(irq_req), 32'd0);
        chk("mreq_nest", 101, 32'(nest_lvl), 32'd0);
        chk("mreq_insvc", 101, 32'(in_service), 32'd0);
        chk("mreq_pend", 101, 32'(pending), 32'd0);
        step(); step();
        chk("mreq_noedge", 102, 32'(irq_req), 32'd0);

        // Reset mid-handler.
        drive(4'h0, 0, 0); step();
        drive(4'h4, 0, 0); step(); step();
        drive(4'h4, 1, 0); step();
        chk("mhnd_nest", 110, 32'(nest_lvl), 32'd1);
        drive(4'h0, 0, 0); rst = 1'b1; step(); rst = 1'b0;
        chk("mhnd_nest", 111, 32'(nest_lvl), 32'd0);
        chk("mhnd_insvc", 111, 32'(in_service), 32'd0);

        // Fill both instances to two levels, then raise src3.
        drive(4'h2, 0, 0); step(); step();
        drive(4'h2, 1, 0); step();
        drive(4'h6, 0, 0); step(); step();
        chk("full_req2", 120, 32'(req2), 32'd1);
        drive(4'h6, 1, 0); step();
        chk("full_nest2", 121, 32'(nest2), 32'd2);
        chk("full_insvc2", 121, 32'(insvc2), 32'h6);
        drive(4'hE, 0, 0); step(); step();
        chk("full_req", 122, 32'(irq_req), 32'd1);
        chk("full_vec", 122, irq_vec, 32'h00AB);
        chk("full_req2", 122, 32'(req2), 32'd0);
        chk("full_pend2", 122, 32'(pend2), 32'h8);
        step();
        chk("full_req2", 123, 32'(req2), 32'd0);
        chk("full_nest2", 123, 32'(nest2), 32'd2);
        chk("full_err2", 123, 32'(err2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
